// File: rtl/sync_event_sched.sv
// sync_event_sched
// Turns single-cycle clock-sync detect pulses from several ports into an
// ordered stream of {port, timestamp} events. Simultaneous detects are
// arbitrated round-robin. A programmable hold-off blocks further grants after
// each accepted event. Accepted events wait in a small first-word-fall-through
// FIFO that the consumer drains with a valid/ready handshake.
//
// Ports
//   aclk, areset       clock (rising edge) and asynchronous active-high reset
//   det_i              detect pulses, one bit per port
//   port_mask_i        1 = port eligible for arbitration
//   enable_i           global accept enable
//   holdoff_cycles_i   blocked cycles after a grant (sampled at grant)
//   evt_valid_o        FIFO non-empty
//   evt_ready_i        consumer takes the head event
//   evt_port_o         port index of the head event
//   evt_ts_o           timestamp of the head event
//   ts_o               free-running timestamp counter
//   drop_cnt_o         saturating count of cycles that lost a request
//   busy_o             high while the hold-off window is running
module sync_event_sched #(
    parameter int NUM_PORTS  = 2,
    parameter int TS_WIDTH   = 48,
    parameter int HOLDOFF_W  = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [NUM_PORTS-1:0] det_i,
    input  logic [NUM_PORTS-1:0] port_mask_i,
    input  logic                 enable_i,
    input  logic [HOLDOFF_W-1:0] holdoff_cycles_i,
    output logic                 evt_valid_o,
    input  logic                 evt_ready_i,
    output logic [PORT_W-1:0]    evt_port_o,
    output logic [TS_WIDTH-1:0]  evt_ts_o,
    output logic [TS_WIDTH-1:0]  ts_o,
    output logic [15:0]          drop_cnt_o,
    output logic                 busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [PORT_W:0] NP   = (PORT_W + 1)'(NUM_PORTS);
    localparam logic [AW:0]     FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, HOLDOFF} state_t;

    state_t                 state_q, state_d;
    logic [HOLDOFF_W-1:0]   hcnt_q, hcnt_d;
    logic [PORT_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [TS_WIDTH-1:0]    ts_q;
    logic [15:0]            drop_cnt_q;

    logic [PORT_W-1:0]      mem_port_q [FIFO_DEPTH];
    logic [TS_WIDTH-1:0]    mem_ts_q   [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [AW:0]            count_q;

    logic [NUM_PORTS-1:0]   req;
    logic [NUM_PORTS-1:0]   gnt_vec;
    logic [PORT_W-1:0]      winner;
    logic                   req_any, full, empty, grant, pop, drop;

    assign req     = enable_i ? (det_i & port_mask_i) : '0;
    assign req_any = |req;
    assign full    = (count_q == FULL);
    assign empty   = (count_q == '0);
    assign pop     = !empty && evt_ready_i;
    assign grant   = (state_q == IDLE) && req_any && !full;

    // Scan offsets from far to near so the nearest set bit at or above the
    // pointer is the last assignment and wins.
    always_comb begin
        logic [PORT_W:0] s;
        winner = '0;
        s      = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            s = {1'b0, rr_ptr_q} + (PORT_W + 1)'(i);
            if (s >= NP) s = s - NP;
            if (req[s[PORT_W-1:0]]) winner = s[PORT_W-1:0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_gnt
            assign gnt_vec[gi] = grant && (winner == PORT_W'(gi));
        end
    endgenerate

    // A drop cycle is any cycle where some requesting bit was not granted;
    // counted once per cycle no matter how many bits were lost.
    assign drop = req_any && ((req & ~gnt_vec) != '0);

    always_comb begin
        logic [PORT_W:0] wn;
        wn       = {1'b0, winner} + 1'b1;
        rr_ptr_d = rr_ptr_q;
        if (grant) rr_ptr_d = (wn == NP) ? '0 : wn[PORT_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        case (state_q)
            IDLE: begin
                if (grant && (holdoff_cycles_i != '0)) begin
                    hcnt_d  = holdoff_cycles_i;
                    state_d = HOLDOFF;
                end
            end
            HOLDOFF: begin
                hcnt_d = hcnt_q - 1'b1;
                if (hcnt_q == HOLDOFF_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= IDLE;
            hcnt_q     <= '0;
            rr_ptr_q   <= '0;
            ts_q       <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            rr_ptr_q <= rr_ptr_d;
            ts_q     <= ts_q + 1'b1;
            if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    // FIFO storage is cleared on reset so the head payload reads 0 until the
    // first event is written.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_port_q[i] <= '0;
                mem_ts_q[i]   <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (grant) begin
                mem_port_q[wr_ptr_q] <= winner;
                mem_ts_q[wr_ptr_q]   <= ts_q;
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (grant && !pop)      count_q <= count_q + 1'b1;
            else if (!grant && pop) count_q <= count_q - 1'b1;
        end
    end

    assign evt_valid_o = !empty;
    assign evt_port_o  = mem_port_q[rd_ptr_q];
    assign evt_ts_o    = mem_ts_q[rd_ptr_q];
    assign ts_o        = ts_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign busy_o      = (state_q == HOLDOFF);

endmodule

// File: tb/tb_sync_event_sched.sv
module tb_sync_event_sched;

    logic        aclk = 1'b0;
    logic        areset;
    logic [1:0]  det_i;
    logic [1:0]  port_mask_i;
    logic        enable_i;
    logic [15:0] holdoff_cycles_i;
    logic        evt_valid_o;
    logic        evt_ready_i;
    logic [0:0]  evt_port_o;
    logic [7:0]  evt_ts_o;
    logic [7:0]  ts_o;
    logic [15:0] drop_cnt_o;
    logic        busy_o;

    sync_event_sched #(
        .NUM_PORTS (2),
        .TS_WIDTH  (8),
        .HOLDOFF_W (16),
        .FIFO_DEPTH(4)
    ) dut (
        .aclk            (aclk),
        .areset          (areset),
        .det_i           (det_i),
        .port_mask_i     (port_mask_i),
        .enable_i        (enable_i),
        .holdoff_cycles_i(holdoff_cycles_i),
        .evt_valid_o     (evt_valid_o),
        .evt_ready_i     (evt_ready_i),
        .evt_port_o      (evt_port_o),
        .evt_ts_o        (evt_ts_o),
        .ts_o            (ts_o),
        .drop_cnt_o      (drop_cnt_o),
        .busy_o          (busy_o)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [0:0] port;
        logic [7:0] ts;
    } ev_t;

    ev_t        q[$];
    logic [7:0] ts_m;
    int         vectors     = 0;
    int         miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        ts_m = ts_m + 8'd1;
    endtask

    // One cycle: drive det/ready, check head of scoreboard, pop on handshake,
    // push an expected event if exp_port >= 0, then advance the clock.
    task automatic cycle(input logic [1:0] det, input logic rdy, input int exp_port);
        ev_t e;
        det_i       = det;
        evt_ready_i = rdy;
        chk("ts_o", ts_o, ts_m);
        chk("evt_valid", evt_valid_o, q.size() != 0);
        if (q.size() != 0) begin
            chk("evt_port", evt_port_o, q[0].port);
            chk("evt_ts", evt_ts_o, q[0].ts);
            if (rdy) begin
                e = q.pop_front();
                $display("pop  port=%0d ts=%0d", e.port, e.ts);
            end
        end
        if (exp_port >= 0) begin
            e.port = exp_port[0:0];
            e.ts   = ts_m;
            q.push_back(e);
            $display("push port=%0d ts=%0d", e.port, e.ts);
        end
        tick();
        det_i = 2'b00;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, evt_valid_o, 0);
        chk({tag, "_port"},  evt_port_o, 0);
        chk({tag, "_evt_ts"}, evt_ts_o, 0);
        chk({tag, "_ts"},    ts_o, 0);
        chk({tag, "_drop"},  drop_cnt_o, 0);
        chk({tag, "_busy"},  busy_o, 0);
    endtask

    initial begin
        areset           = 1'b1;
        det_i            = 2'b00;
        port_mask_i      = 2'b11;
        enable_i         = 1'b1;
        holdoff_cycles_i = 16'd3;
        evt_ready_i      = 1'b1;
        ts_m             = 8'd0;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        chk_all_zero("reset");
        areset = 1'b0;
        ts_m   = 8'd0;

        // Single event with hold-off H=3
        while (ts_m < 8'd10) cycle(2'b00, 1'b1, -1);
        cycle(2'b01, 1'b1, 0);            // grant at ts 10
        chk("busy_11", busy_o, 1);
        cycle(2'b00, 1'b1, -1);
        chk("busy_12", busy_o, 1);
        cycle(2'b01, 1'b1, -1);           // blocked by hold-off
        chk("busy_13", busy_o, 1);
        cycle(2'b00, 1'b1, -1);
        chk("busy_14", busy_o, 0);
        chk("drop_t1", drop_cnt_o, 1);
        cycle(2'b01, 1'b1, 0);            // grant at ts 14
        holdoff_cycles_i = 16'd0;
        repeat (3) cycle(2'b00, 1'b1, -1);
        chk("busy_end_t1", busy_o, 0);

        // Round-robin with H=0; pointer is 1 here, port 1 alone brings it to 0
        cycle(2'b10, 1'b1, 1);
        cycle(2'b11, 1'b1, 0);
        cycle(2'b11, 1'b1, 1);
        cycle(2'b11, 1'b1, 0);
        chk("busy_h0", busy_o, 0);
        cycle(2'b00, 1'b1, -1);
        chk("drop_rr", drop_cnt_o, 4);
        cycle(2'b00, 1'b1, -1);

        // FIFO full with simultaneous pop
        repeat (4) cycle(2'b01, 1'b0, 0);
        cycle(2'b01, 1'b1, -1);           // pop succeeds, push dropped
        chk("drop_full", drop_cnt_o, 5);
        repeat (3) cycle(2'b00, 1'b1, -1);
        cycle(2'b00, 1'b1, -1);           // occupancy was 3: now empty

        // Mask and enable
        port_mask_i = 2'b10;
        cycle(2'b01, 1'b1, -1);
        chk("drop_mask", drop_cnt_o, 5);
        port_mask_i = 2'b11;
        cycle(2'b01, 1'b0, 0);
        cycle(2'b01, 1'b0, 0);
        enable_i = 1'b0;
        cycle(2'b10, 1'b1, -1);
        cycle(2'b10, 1'b1, -1);
        cycle(2'b00, 1'b1, -1);
        chk("drop_enable", drop_cnt_o, 5);
        enable_i = 1'b1;

        // Drop counter saturation: fill FIFO, then hammer it
        repeat (4) cycle(2'b01, 1'b0, 0);
        det_i       = 2'b01;
        evt_ready_i = 1'b0;
        for (int i = 0; i < 70000; i++) tick();
        det_i = 2'b00;
        chk("drop_sat", drop_cnt_o, 16'hFFFF);
        repeat (4) cycle(2'b00, 1'b1, -1);
        cycle(2'b00, 1'b1, -1);
        chk("drop_sat_hold", drop_cnt_o, 16'hFFFF);

        // Timestamp wrap 255 -> 0
        for (int i = 0; i < 256 && ts_m != 8'd255; i++) tick();
        chk("ts_255", ts_o, 8'd255);
        tick();
        chk("ts_wrap", ts_o, 8'd0);

        // Mid-operation reset with two events queued and busy high
        holdoff_cycles_i = 16'd0;
        cycle(2'b01, 1'b0, 0);
        holdoff_cycles_i = 16'd5;
        cycle(2'b01, 1'b0, 0);            // pointer now 1
        chk("busy_pre_rst", busy_o, 1);
        chk("valid_pre_rst", evt_valid_o, 1);
        #2;
        areset = 1'b1;
        #1;
        chk_all_zero("midrst");
        q.delete();
        #1;
        areset = 1'b0;
        ts_m   = 8'd0;
        holdoff_cycles_i = 16'd0;
        cycle(2'b11, 1'b1, 0);            // pointer reset: port 0 wins
        cycle(2'b00, 1'b1, -1);
        chk("drop_post_rst", drop_cnt_o, 1);
        cycle(2'b00, 1'b1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sync_event_sched.md
# sync_event_sched

Sequences clock-sync detect pulses from the per-port VLAN sync detectors into an ordered, timestamped event stream. It sits in the 250 MHz user logic box after the packet-detect instances. It arbitrates simultaneous detects round-robin, enforces a programmable hold-off between accepted events, and timestamps each accepted event from a free-running counter. Accepted events are buffered in a small FIFO that the sync consumer drains over a valid/ready handshake.

## Interface
- NUM_PORTS, 2: number of detector inputs, >= 1.
- TS_WIDTH, 48: timestamp counter width.
- HOLDOFF_W, 16: hold-off counter width.
- FIFO_DEPTH, 4: event FIFO entries; must be a power of 2, >= 2.
- PORT_W (derived): $clog2(NUM_PORTS), or 1 when NUM_PORTS == 1.

- aclk  in  1  clock; everything is on the rising edge.
- areset  in  1  asynchronous active-high reset.
- det_i  in  NUM_PORTS  single-cycle detect pulses, one bit per port.
- port_mask_i  in  NUM_PORTS  1 = port eligible.
- enable_i  in  1  global accept enable.
- holdoff_cycles_i  in  HOLDOFF_W  minimum blocked cycles after a grant.
- evt_valid_o  out  1  FIFO non-empty.
- evt_ready_i  in  1  consumer accepts the head event.
- evt_port_o  out  PORT_W  winning port index of the head event.
- evt_ts_o  out  TS_WIDTH  timestamp of the head event.
- ts_o  out  TS_WIDTH  free-running timestamp counter.
- drop_cnt_o  out  16  saturating count of drop cycles.
- busy_o  out  1  high while the FSM is in HOLDOFF.

## Operation
- Timestamp counter ts_o:
  - Increments by 1 every cycle.
  - Wraps modulo 2^TS_WIDTH.
- Request vector: req = det_i & port_mask_i, gated by enable_i.
- Round-robin arbiter:
  - Pointer rr_ptr (reset 0) marks the highest-priority port.
  - The winner is the first set req bit at or above rr_ptr, wrapping.
  - On a grant, rr_ptr becomes (winner+1) mod NUM_PORTS. Without a grant, rr_ptr holds.
- FSM state IDLE:
  - Grant occurs when req != 0 and the FIFO is not full.
  - On grant, push {winner, ts_o of this cycle}.
  - If holdoff_cycles_i == 0, stay in IDLE.
  - Otherwise load hcnt = holdoff_cycles_i (sampled at grant only) and go to HOLDOFF.
- FSM state HOLDOFF:
  - hcnt decrements each cycle.
  - When hcnt == 1, return to IDLE next cycle.
  - No grants occur in this state.
- Drop cycle: any cycle in which req != 0 and at least one set req bit is not granted. Covers arbitration losers, HOLDOFF and FIFO full.
  - drop_cnt_o += 1 per drop cycle, regardless of how many bits are lost.
  - drop_cnt_o saturates at 0xFFFF.
- FIFO:
  - First-word-fall-through: evt_valid_o = !empty.
  - Pop on evt_valid_o && evt_ready_i.
  - Full is evaluated on current occupancy before the same-cycle pop, so a push while full is dropped even if a pop happens.
  - Push and pop in the same non-full cycle: occupancy is unchanged.
- enable_i low:
  - No grants.
  - HOLDOFF keeps counting.
  - FIFO keeps draining.
  - Masked or disabled detects are not drops.
- Reset, including mid-operation:
  - FIFO is emptied and all buffered events are lost.
  - FSM goes to IDLE; hcnt, rr_ptr, ts_o and drop_cnt_o go to 0.

## Timing
- Reset values: every output is 0 (evt_valid_o, evt_port_o, evt_ts_o, ts_o, drop_cnt_o, busy_o).
- Grant latency: a grant at cycle N gives evt_valid_o = 1 at N+1 if the FIFO was empty.
  - That event's evt_ts_o equals the ts_o value at cycle N.
- Hold-off window, for a grant at N with H = holdoff_cycles_i:
  - busy_o is high for cycles N+1 .. N+H.
  - The next grant is possible at N+H+1.
  - H = 0 allows a grant every cycle.
- Stall: while evt_valid_o && !evt_ready_i, evt_port_o and evt_ts_o are stable.
- Payload when evt_valid_o = 0: don't-care after the first push, 0 before it.
- Throughput: one push and one pop per cycle at most.

## Test plan
- Single event: NUM_PORTS=2, H=3, det_i=01 at cycle 10 (ts=10) -> evt_valid_o at 11, port 0, ts 10; busy_o high cycles 11-13; det_i=01 at 12 -> drop_cnt_o=1; det_i=01 at 14 -> granted, ts 14.
- Round-robin: H=0, det_i=11 on cycles 5, 6, 7 -> ports granted 0, 1, 0; drop_cnt_o=3.
- FIFO full with simultaneous pop: H=0, FIFO_DEPTH=4, evt_ready_i=0, det_i=01 on cycles 0-3 -> 4 events; on cycle 4, det_i=01 and evt_ready_i=1 -> pop succeeds, push dropped; occupancy 3, drop_cnt_o=1.
- Mask and enable: port_mask_i=10, det_i=01 -> no event, no drop; enable_i=0, det_i=10 -> no event; queued events still drain with evt_ready_i=1.
- Saturation and wrap: TS_WIDTH=8 -> ts_o goes 255 to 0; 70000 forced drop cycles -> drop_cnt_o=0xFFFF.
- Mid-operation reset: assert areset with 2 events queued and busy_o=1 -> all outputs 0 asynchronously; after release, det_i=01 is granted immediately.
